// File: rtl/arm_pipe_pkg.sv
// Shared types and helpers for the ARM pipeline stages (IF/ID latch layout, PC arithmetic).
package arm_pipe_pkg;

    localparam int PC_W = 32;
    localparam logic [31:0]     NOP_INST = 32'hE1A0_0000;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] PC_INC4  = 32'd4;
    localparam logic [PC_W-1:0] PC_INC8  = 32'd8;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc8;
        logic            valid;
    } if_id_t;

    // Wraps silently at the top of the address space.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc,
                                                input logic [PC_W-1:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Enable/flush pipeline latch of if_id_t: flush loads a bubble, !en holds, else loads d.
// Bubbles keep the previous pc/pc8 so downstream never sees X.
module if_id_reg
    import arm_pipe_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    // Pipeline latch state: reset > flush > hold > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r.inst  <= BUBBLE_INST;
            q_r.pc    <= {PC_W{1'b0}};
            q_r.pc8   <= PC_INC8;
            q_r.valid <= 1'b0;
        end else if (flush) begin
            q_r.inst  <= BUBBLE_INST;
            q_r.valid <= 1'b0;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the imem address and registers the IF/ID latch.
// Optional FETCH_PERF_CNT_EN adds perf_fetch / perf_bubble counters.
module fetch_stage #(
    parameter int              PC_W     = arm_pipe_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = arm_pipe_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INST = arm_pipe_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_src,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     ifid_inst,
    output logic [PC_W-1:0] ifid_pc,
    output logic [PC_W-1:0] ifid_pc8,
    output logic            ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_bubble
`endif
);

    import arm_pipe_pkg::if_id_t;
    import arm_pipe_pkg::pc_next;

    localparam logic [PC_W-1:0] WORD_MASK = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] INC4      = arm_pipe_pkg::PC_INC4;
    localparam logic [PC_W-1:0] INC8      = arm_pipe_pkg::PC_INC8;

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic            flush_s;
    logic            en_s;
    if_id_t          ifid_d_s;
    if_id_t          ifid_q_s;

    // Redirect and imem-not-ready both insert a bubble; a redirect overrides stall.
    assign flush_s = pc_src | (~stall & ~imem_ready);
    assign en_s    = ~stall;

    // Next-PC selection: pc_src > stall > !imem_ready > sequential.
    always_comb begin
        pc_nxt_s = pc_r;
        if (pc_src) begin
            pc_nxt_s = branch_target & WORD_MASK;
        end else if (stall) begin
            pc_nxt_s = pc_r;
        end else if (!imem_ready) begin
            pc_nxt_s = pc_r;
        end else begin
            pc_nxt_s = pc_next(pc_r, INC4);
        end
    end

    // PC register; imem_addr is this register, so stall/pc_src never reach it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    // Candidate IF/ID contents for a normal fetch.
    always_comb begin
        ifid_d_s.inst  = imem_rdata;
        ifid_d_s.pc    = pc_r;
        ifid_d_s.pc8   = pc_next(pc_r, INC8);
        ifid_d_s.valid = 1'b1;
    end

    if_id_reg #(
        .BUBBLE_INST (NOP_INST)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en_s),
        .flush (flush_s),
        .d     (ifid_d_s),
        .q     (ifid_q_s)
    );

    assign imem_addr  = pc_r;
    assign ifid_inst  = ifid_q_s.inst;
    assign ifid_pc    = ifid_q_s.pc;
    assign ifid_pc8   = ifid_q_s.pc8;
    assign ifid_valid = ifid_q_s.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_bubble_r;
    logic        fetch_s;

    assign fetch_s = ~pc_src & ~stall & imem_ready;

    // Performance counters: real loads vs bubble loads; stall cycles count as neither.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_r  <= 32'd0;
            perf_bubble_r <= 32'd0;
        end else begin
            perf_fetch_r  <= perf_fetch_r  + {31'd0, fetch_s};
            perf_bubble_r <= perf_bubble_r + {31'd0, flush_s};
        end
    end

    assign perf_fetch  = perf_fetch_r;
    assign perf_bubble = perf_bubble_r;
`else
    // Counters compiled out.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic        imem_ready = 1'b1;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc8;
    logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .ifid_inst     (ifid_inst),
        .ifid_pc       (ifid_pc),
        .ifid_pc8      (ifid_pc8),
        .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_bubble   (perf_bubble)
`endif
    );

    // Instruction memory model: mem[a] = a, same-cycle read.
    assign imem_rdata = imem_addr;

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic        chk_perf;
        logic [31:0] pf;
        logic [31:0] pb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Monitor: after each active edge, compare DUT outputs with the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "imem_addr",  imem_addr,  e.addr);
            chk(e.name, "ifid_inst",  ifid_inst,  e.inst);
            chk(e.name, "ifid_pc",    ifid_pc,    e.pc);
            chk(e.name, "ifid_pc8",   ifid_pc8,   e.pc8);
            chk(e.name, "ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
`ifdef FETCH_PERF_CNT_EN
            if (e.chk_perf) begin
                chk(e.name, "perf_fetch",  perf_fetch,  e.pf);
                chk(e.name, "perf_bubble", perf_bubble, e.pb);
            end
`endif
        end
    end

    // Apply one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input string name, input logic r, input logic s, input logic p,
                        input logic [31:0] tgt, input logic rdy,
                        input logic [31:0] addr, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [31:0] pc8, input logic v,
                        input logic cp = 1'b0, input logic [31:0] pf = 32'd0,
                        input logic [31:0] pb = 32'd0);
        exp_t e;
        @(negedge clk);
        reset = r; stall = s; pc_src = p; branch_target = tgt; imem_ready = rdy;
        e.name = name; e.addr = addr; e.inst = inst; e.pc = pc; e.pc8 = pc8;
        e.valid = v; e.chk_perf = cp; e.pf = pf; e.pb = pb;
        sb.push_back(e);
    endtask

    initial begin
        // reset, then sequential fetch
        step("rst0", 1, 0, 0, 32'h0, 1, 32'h0, NOP, 32'h0, 32'h8, 0);
        step("rst1", 1, 0, 0, 32'h0, 1, 32'h0, NOP, 32'h0, 32'h8, 0);
        step("rst2", 1, 0, 0, 32'h0, 1, 32'h0, NOP, 32'h0, 32'h8, 0, 1, 32'd0, 32'd0);
        step("seq0", 0, 0, 0, 32'h0, 1, 32'h4, 32'h0, 32'h0, 32'h8, 1);
        step("seq1", 0, 0, 0, 32'h0, 1, 32'h8, 32'h4, 32'h4, 32'hC, 1);
        step("seq2", 0, 0, 0, 32'h0, 1, 32'hC, 32'h8, 32'h8, 32'h10, 1);
        step("seq3", 0, 0, 0, 32'h0, 1, 32'h10, 32'hC, 32'hC, 32'h14, 1);
        // hazard stall at 0x10
        step("stl0", 0, 1, 0, 32'h0, 1, 32'h10, 32'hC, 32'hC, 32'h14, 1);
        step("stl1", 0, 1, 0, 32'h0, 1, 32'h10, 32'hC, 32'hC, 32'h14, 1);
        step("stlx", 0, 0, 0, 32'h0, 1, 32'h14, 32'h10, 32'h10, 32'h18, 1);
        // redirect wins over stall
        step("brst", 0, 1, 1, 32'h100, 1, 32'h100, NOP, 32'h10, 32'h18, 0);
        step("brf",  0, 0, 0, 32'h0, 1, 32'h104, 32'h100, 32'h100, 32'h108, 1);
        step("bral", 0, 0, 1, 32'h203, 1, 32'h200, NOP, 32'h100, 32'h108, 0);
        // imem not ready at 0x20
        step("br20", 0, 0, 1, 32'h20, 1, 32'h20, NOP, 32'h100, 32'h108, 0);
        step("nr0",  0, 0, 0, 32'h0, 0, 32'h20, NOP, 32'h100, 32'h108, 0);
        step("nr1",  0, 0, 0, 32'h0, 0, 32'h20, NOP, 32'h100, 32'h108, 0);
        step("nrst", 0, 1, 0, 32'h0, 0, 32'h20, NOP, 32'h100, 32'h108, 0);
        step("nrok", 0, 0, 0, 32'h0, 1, 32'h24, 32'h20, 32'h20, 32'h28, 1);
        // wrap at top of address space, then reset during stall / redirect
        step("brtop", 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, NOP, 32'h20, 32'h28, 0);
        step("wrap",  0, 0, 0, 32'h0, 1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4, 1);
        step("wstl",  0, 1, 0, 32'h0, 1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4, 1);
        step("rstst", 1, 1, 0, 32'h0, 1, 32'h0, NOP, 32'h0, 32'h8, 0);
        step("rsf0",  0, 0, 0, 32'h0, 1, 32'h4, 32'h0, 32'h0, 32'h8, 1);
        step("rstbr", 1, 0, 1, 32'h300, 1, 32'h0, NOP, 32'h0, 32'h8, 0);
        step("rsf1",  0, 0, 0, 32'h0, 1, 32'h4, 32'h0, 32'h0, 32'h8, 1);
        // counter scenario: 5 fetches, 1 redirect, 2 not-ready, 3 stalls
        step("prst", 1, 0, 0, 32'h0, 1, 32'h0, NOP, 32'h0, 32'h8, 0, 1, 32'd0, 32'd0);
        step("pf0",  0, 0, 0, 32'h0, 1, 32'h4, 32'h0, 32'h0, 32'h8, 1);
        step("pf1",  0, 0, 0, 32'h0, 1, 32'h8, 32'h4, 32'h4, 32'hC, 1);
        step("pf2",  0, 0, 0, 32'h0, 1, 32'hC, 32'h8, 32'h8, 32'h10, 1);
        step("pf3",  0, 0, 0, 32'h0, 1, 32'h10, 32'hC, 32'hC, 32'h14, 1);
        step("pf4",  0, 0, 0, 32'h0, 1, 32'h14, 32'h10, 32'h10, 32'h18, 1, 1, 32'd5, 32'd0);
        step("pbr",  0, 0, 1, 32'h40, 1, 32'h40, NOP, 32'h10, 32'h18, 0);
        step("pnr0", 0, 0, 0, 32'h0, 0, 32'h40, NOP, 32'h10, 32'h18, 0);
        step("pnr1", 0, 0, 0, 32'h0, 0, 32'h40, NOP, 32'h10, 32'h18, 0);
        step("pst0", 0, 1, 0, 32'h0, 1, 32'h40, NOP, 32'h10, 32'h18, 0);
        step("pst1", 0, 1, 0, 32'h0, 1, 32'h40, NOP, 32'h10, 32'h18, 0);
        step("pst2", 0, 1, 0, 32'h0, 1, 32'h40, NOP, 32'h10, 32'h18, 0, 1, 32'd5, 32'd3);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
